gen_step_scheduler: RTL and testbench

Sequences generation updates of the Game of Life field. A programmable tick timer drives the run mode, with pause and single-step, and each new buffer is swapped in only during vertical blanking. The block arbitrates the field between the life step engine and the field config loader: a load is granted only between steps. It sits between the user command decoder and the step engine / field_cfg_loader pair.

---
 rtl/gen_step_scheduler.sv | 154 +++++++++++++++
 tb/tb_gen_step_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gen_step_scheduler
//  Description : Paces Game of Life generations (run/pause/single-step tick
//                timer), swaps buffers in vblank, arbitrates field loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_step_scheduler #(
    parameter int BASE_PERIOD = 1_000_000,
    parameter int SPEED_W     = 3,
    parameter int GEN_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cmd_run_toggle,
    input  logic               i_cmd_step,
    input  logic               i_cmd_speed_up,
    input  logic               i_cmd_speed_down,
    input  logic               i_load_req,
    input  logic               i_is_loading,
    input  logic               i_step_done,
    input  logic               i_vblank,
    output logic               o_step_go,
    output logic               o_swap,
    output logic               o_fcl_allowed,
    output logic               o_running,
    output logic [SPEED_W-1:0] o_speed,
    output logic [GEN_W-1:0]   o_gen_count
);

    localparam int              c_timer_w   = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam logic [31:0]     c_base      = 32'(BASE_PERIOD);
    localparam logic [SPEED_W-1:0] c_speed_max = {SPEED_W{1'b1}};

    localparam logic [2:0] c_idle        = 3'd0;
    localparam logic [2:0] c_start_step  = 3'd1;
    localparam logic [2:0] c_wait_step   = 3'd2;
    localparam logic [2:0] c_wait_vblank = 3'd3;
    localparam logic [2:0] c_load        = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 r_running;
    logic [SPEED_W-1:0]   r_speed;
    logic [GEN_W-1:0]     r_gen_count;
    logic                 r_tick_pending;
    logic                 r_step_pending;
    logic                 r_swap;
    logic [c_timer_w-1:0] r_timer;

    logic                 w_run_next;
    logic                 w_load_exit;
    logic                 w_counting;
    logic                 w_timer_zero;
    logic                 w_consume;
    logic                 w_swap_now;
    logic [c_timer_w-1:0] w_reload;

    assign w_run_next   = r_running ^ i_cmd_run_toggle;
    assign w_load_exit  = (r_state == c_load) && !i_load_req && !i_is_loading;
    assign w_counting   = r_running && (r_state != c_load);
    assign w_timer_zero = (r_timer == '0);
    assign w_consume    = (r_state == c_idle) && !i_load_req;
    assign w_swap_now   = (r_state == c_wait_vblank) && i_vblank;
    // Period follows the speed sampled at reload time, not mid-count.
    assign w_reload     = c_timer_w'((c_base >> r_speed) - 32'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a load request outranks any pending step
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (i_load_req) begin
                    w_state_next = c_load;
                end else if (r_tick_pending || r_step_pending) begin
                    w_state_next = c_start_step;
                end
            end
            c_start_step:  w_state_next = c_wait_step;
            c_wait_step:   if (i_step_done) w_state_next = c_wait_vblank;
            c_wait_vblank: if (i_vblank) w_state_next = c_idle;
            c_load:        if (w_load_exit) w_state_next = c_idle;
            default:       w_state_next = c_idle;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        o_step_go     = (r_state == c_start_step);
        o_fcl_allowed = (r_state == c_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running      <= 1'b0;
            r_speed        <= '0;
            r_gen_count    <= '0;
            r_tick_pending <= 1'b0;
            r_step_pending <= 1'b0;
            r_swap         <= 1'b0;
            r_timer        <= c_timer_w'(c_base - 32'd1);
        end else begin
            r_running <= w_run_next;
            r_swap    <= w_swap_now;

            if (i_cmd_run_toggle && !r_running) begin
                r_timer <= w_reload;
            end else if (w_load_exit) begin
                r_timer <= w_reload;
            end else if (w_counting) begin
                r_timer <= w_timer_zero ? w_reload : r_timer - c_timer_w'(1);
            end

            // Later assignments take precedence: a fresh tick survives a
            // same-cycle consume, while pause and load exit always clear.
            if (w_consume) r_tick_pending <= 1'b0;
            if (w_counting && w_timer_zero) r_tick_pending <= 1'b1;
            if (i_cmd_run_toggle && r_running) r_tick_pending <= 1'b0;
            if (w_load_exit) r_tick_pending <= 1'b0;

            if (w_consume) r_step_pending <= 1'b0;
            if (w_load_exit) r_step_pending <= 1'b0;
            if (i_cmd_step && !w_run_next) r_step_pending <= 1'b1;

            if (w_load_exit) begin
                r_gen_count <= '0;
            end else if (w_swap_now) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end

            if (i_cmd_speed_up && !i_cmd_speed_down && (r_speed != c_speed_max)) begin
                r_speed <= r_speed + SPEED_W'(1);
            end else if (i_cmd_speed_down && !i_cmd_speed_up && (r_speed != '0)) begin
                r_speed <= r_speed - SPEED_W'(1);
            end
        end
    end

    assign o_swap      = r_swap;
    assign o_running   = r_running;
    assign o_speed     = r_speed;
    assign o_gen_count = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_gen_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gen_step_scheduler
//  Description : Directed self-checking bench for gen_step_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_step_scheduler;

    localparam int BASE_PERIOD = 8;
    localparam int SPEED_W     = 2;
    localparam int GEN_W       = 16;

    logic               clk;
    logic               rst_n;
    logic               i_cmd_run_toggle;
    logic               i_cmd_step;
    logic               i_cmd_speed_up;
    logic               i_cmd_speed_down;
    logic               i_load_req;
    logic               i_is_loading;
    logic               i_step_done;
    logic               i_vblank;
    logic               o_step_go;
    logic               o_swap;
    logic               o_fcl_allowed;
    logic               o_running;
    logic [SPEED_W-1:0] o_speed;
    logic [GEN_W-1:0]   o_gen_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int go_cnt   = 0;
    int swap_cnt = 0;
    int done_delay = 2;

    gen_step_scheduler #(
        .BASE_PERIOD(BASE_PERIOD),
        .SPEED_W    (SPEED_W),
        .GEN_W      (GEN_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cmd_run_toggle(i_cmd_run_toggle),
        .i_cmd_step      (i_cmd_step),
        .i_cmd_speed_up  (i_cmd_speed_up),
        .i_cmd_speed_down(i_cmd_speed_down),
        .i_load_req      (i_load_req),
        .i_is_loading    (i_is_loading),
        .i_step_done     (i_step_done),
        .i_vblank        (i_vblank),
        .o_step_go       (o_step_go),
        .o_swap          (o_swap),
        .o_fcl_allowed   (o_fcl_allowed),
        .o_running       (o_running),
        .o_speed         (o_speed),
        .o_gen_count     (o_gen_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_step_go) go_cnt <= go_cnt + 1;
        if (o_swap) swap_cnt <= swap_cnt + 1;
    end

    // Step engine model: done pulse done_delay cycles after go is seen
    initial begin
        i_step_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_step_go) begin
                repeat (done_delay) @(negedge clk);
                i_step_done = 1'b1;
                @(negedge clk);
                i_step_done = 1'b0;
            end
        end
    end

    task automatic wait_go(input int limit, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (o_step_go) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_toggle(output int t_edge);
        @(negedge clk);
        i_cmd_run_toggle = 1'b1;
        t_edge = cyc + 1;
        @(negedge clk);
        i_cmd_run_toggle = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (o_step_go !== 1'b0) $display("FAIL reset_step_go: got %b want 0", o_step_go); else n_pass++;
        n_checks++; if (o_swap !== 1'b0) $display("FAIL reset_swap: got %b want 0", o_swap); else n_pass++;
        n_checks++; if (o_fcl_allowed !== 1'b0) $display("FAIL reset_fcl: got %b want 0", o_fcl_allowed); else n_pass++;
        n_checks++; if (o_running !== 1'b0) $display("FAIL reset_running: got %b want 0", o_running); else n_pass++;
        n_checks++; if (o_speed !== 2'd0) $display("FAIL reset_speed: got %0d want 0", o_speed); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd0) $display("FAIL reset_gen: got %0d want 0", o_gen_count); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (o_step_go !== 1'b0) $display("FAIL idle_no_go: got %b want 0", o_step_go); else n_pass++;
    endtask

    task automatic test_periodic_run;
        int t0, t1, t2, g0;
        bit ok;
        pulse_toggle(t0);
        n_checks++; if (o_running !== 1'b1) $display("FAIL run_on: got %b want 1", o_running); else n_pass++;
        wait_go(40, t1, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL run_first_go_timeout: got %b want 1", ok); else n_pass++;
        n_checks++; if (t1 !== t0 + 9) $display("FAIL run_first_go_time: got %0d want %0d", t1 - t0, 9); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            repeat (4) @(negedge clk);
            n_checks++; if (o_swap !== 1'b1) $display("FAIL run_swap_%0d: got %b want 1", k, o_swap); else n_pass++;
            n_checks++; if (o_gen_count !== 16'(k)) $display("FAIL run_gen_%0d: got %0d want %0d", k, o_gen_count, k); else n_pass++;
            if (k < 3) begin
                wait_go(40, t2, ok);
                n_checks++; if (t2 !== t1 + 8) $display("FAIL run_period_%0d: got %0d want 8", k, t2 - t1); else n_pass++;
                t1 = t2;
            end
        end
        pulse_toggle(t0);
        g0 = go_cnt;
        repeat (20) @(negedge clk);
        n_checks++; if (o_running !== 1'b0) $display("FAIL pause_running: got %b want 0", o_running); else n_pass++;
        n_checks++; if (go_cnt - g0 !== 0) $display("FAIL pause_no_go: got %0d want 0", go_cnt - g0); else n_pass++;
    endtask

    task automatic test_single_step;
        int g0, s0, t;
        bit ok;
        g0 = go_cnt; s0 = swap_cnt;
        @(negedge clk); i_cmd_step = 1'b1;
        @(negedge clk); i_cmd_step = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (go_cnt - g0 !== 1) $display("FAIL step_one_go: got %0d want 1", go_cnt - g0); else n_pass++;
        n_checks++; if (swap_cnt - s0 !== 1) $display("FAIL step_one_swap: got %0d want 1", swap_cnt - s0); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd4) $display("FAIL step_gen: got %0d want 4", o_gen_count); else n_pass++;
        g0 = go_cnt; s0 = swap_cnt;
        @(negedge clk); i_cmd_step = 1'b1;
        @(negedge clk); i_cmd_step = 1'b0;
        wait_go(20, t, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL step_go_timeout: got %b want 1", ok); else n_pass++;
        @(negedge clk); i_cmd_step = 1'b1;
        @(negedge clk); i_cmd_step = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (go_cnt - g0 !== 2) $display("FAIL step_queued_go: got %0d want 2", go_cnt - g0); else n_pass++;
        n_checks++; if (swap_cnt - s0 !== 2) $display("FAIL step_queued_swap: got %0d want 2", swap_cnt - s0); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd6) $display("FAIL step_queued_gen: got %0d want 6", o_gen_count); else n_pass++;
    endtask

    task automatic test_overrun;
        int t0, t1, t2, g0, s0, tp;
        bit ok;
        done_delay = 20;
        pulse_toggle(t0);
        wait_go(40, t1, ok);
        n_checks++; if (t1 !== t0 + 9) $display("FAIL ovr_first_go: got %0d want 9", t1 - t0); else n_pass++;
        s0 = swap_cnt;
        wait_go(60, t2, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL ovr_second_timeout: got %b want 1", ok); else n_pass++;
        n_checks++; if (t2 !== t1 + 23) $display("FAIL ovr_second_go: got %0d want 23", t2 - t1); else n_pass++;
        n_checks++; if (swap_cnt - s0 !== 1) $display("FAIL ovr_swap_before: got %0d want 1", swap_cnt - s0); else n_pass++;
        pulse_toggle(tp);
        g0 = go_cnt; s0 = swap_cnt;
        repeat (45) @(negedge clk);
        n_checks++; if (go_cnt - g0 !== 0) $display("FAIL ovr_no_burst: got %0d want 0", go_cnt - g0); else n_pass++;
        n_checks++; if (swap_cnt - s0 !== 1) $display("FAIL ovr_inflight_swap: got %0d want 1", swap_cnt - s0); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd8) $display("FAIL ovr_gen: got %0d want 8", o_gen_count); else n_pass++;
        done_delay = 2;
    endtask

    task automatic test_load_arbitration;
        int t0, g, l, t, tp, early;
        bit ok;
        early = 0;
        i_vblank = 1'b0;
        pulse_toggle(t0);
        wait_go(40, g, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL load_go_timeout: got %b want 1", ok); else n_pass++;
        repeat (3) @(negedge clk);
        i_load_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_fcl_allowed !== 1'b0) early++;
        end
        n_checks++; if (early !== 0) $display("FAIL load_early_grant: got %0d cycles want 0", early); else n_pass++;
        i_vblank = 1'b1;
        @(negedge clk);
        n_checks++; if (o_swap !== 1'b1) $display("FAIL load_swap: got %b want 1", o_swap); else n_pass++;
        n_checks++; if (o_fcl_allowed !== 1'b0) $display("FAIL load_grant_on_swap: got %b want 0", o_fcl_allowed); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd9) $display("FAIL load_gen_swap: got %0d want 9", o_gen_count); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_fcl_allowed !== 1'b1) $display("FAIL load_grant: got %b want 1", o_fcl_allowed); else n_pass++;
        i_is_loading = 1'b1;
        @(negedge clk);
        i_load_req = 1'b0;
        @(negedge clk);
        n_checks++; if (o_fcl_allowed !== 1'b1) $display("FAIL load_hold_busy: got %b want 1", o_fcl_allowed); else n_pass++;
        i_is_loading = 1'b0;
        l = cyc;
        @(negedge clk);
        n_checks++; if (o_fcl_allowed !== 1'b0) $display("FAIL load_release: got %b want 0", o_fcl_allowed); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd0) $display("FAIL load_gen_clear: got %0d want 0", o_gen_count); else n_pass++;
        wait_go(30, t, ok);
        n_checks++; if (t !== l + 10) $display("FAIL load_full_period: got %0d want 10", t - l); else n_pass++;
        pulse_toggle(tp);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_speed;
        int t0, g1, g2, tp;
        bit ok;
        @(negedge clk); i_cmd_speed_up = 1'b1;
        repeat (4) @(negedge clk);
        i_cmd_speed_up = 1'b0;
        n_checks++; if (o_speed !== 2'd3) $display("FAIL speed_up_sat: got %0d want 3", o_speed); else n_pass++;
        pulse_toggle(t0);
        wait_go(20, g1, ok);
        n_checks++; if (g1 !== t0 + 2) $display("FAIL speed_fast_first_go: got %0d want 2", g1 - t0); else n_pass++;
        wait_go(20, g2, ok);
        n_checks++; if (g2 !== g1 + 5) $display("FAIL speed_fast_back_to_back: got %0d want 5", g2 - g1); else n_pass++;
        pulse_toggle(tp);
        repeat (10) @(negedge clk);
        i_cmd_speed_down = 1'b1;
        repeat (5) @(negedge clk);
        i_cmd_speed_down = 1'b0;
        n_checks++; if (o_speed !== 2'd0) $display("FAIL speed_down_sat: got %0d want 0", o_speed); else n_pass++;
        i_cmd_speed_up = 1'b1;
        @(negedge clk);
        i_cmd_speed_up = 1'b0;
        n_checks++; if (o_speed !== 2'd1) $display("FAIL speed_up_one: got %0d want 1", o_speed); else n_pass++;
        i_cmd_speed_up = 1'b1; i_cmd_speed_down = 1'b1;
        @(negedge clk);
        i_cmd_speed_up = 1'b0; i_cmd_speed_down = 1'b0;
        n_checks++; if (o_speed !== 2'd1) $display("FAIL speed_both: got %0d want 1", o_speed); else n_pass++;
    endtask

    task automatic test_reset_mid_step;
        int t0, g, g0, s0;
        bit ok;
        pulse_toggle(t0);
        wait_go(20, g, ok);
        n_checks++; if (g !== t0 + 5) $display("FAIL rst_go_time: got %0d want 5", g - t0); else n_pass++;
        @(negedge clk);
        g0 = go_cnt; s0 = swap_cnt;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (o_running !== 1'b0) $display("FAIL rst_async_running: got %b want 0", o_running); else n_pass++;
        n_checks++; if (o_speed !== 2'd0) $display("FAIL rst_async_speed: got %0d want 0", o_speed); else n_pass++;
        n_checks++; if (o_gen_count !== 16'd0) $display("FAIL rst_async_gen: got %0d want 0", o_gen_count); else n_pass++;
        n_checks++; if ({o_step_go, o_swap, o_fcl_allowed} !== 3'b000) $display("FAIL rst_async_pulses: got %b want 000", {o_step_go, o_swap, o_fcl_allowed}); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (swap_cnt - s0 !== 0) $display("FAIL rst_no_swap: got %0d want 0", swap_cnt - s0); else n_pass++;
        n_checks++; if (go_cnt - g0 !== 0) $display("FAIL rst_no_go: got %0d want 0", go_cnt - g0); else n_pass++;
    endtask

    initial begin
        rst_n            = 1'b0;
        i_cmd_run_toggle = 1'b0;
        i_cmd_step       = 1'b0;
        i_cmd_speed_up   = 1'b0;
        i_cmd_speed_down = 1'b0;
        i_load_req       = 1'b0;
        i_is_loading     = 1'b0;
        i_vblank         = 1'b1;
        test_reset();
        test_periodic_run();
        test_single_step();
        test_overrun();
        test_load_arbitration();
        test_speed();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
